md_unit_ctrl: RTL

- Multi-cycle multiply/divide controller in the E stage of the 5-stage pipeline.
- Owns the HI/LO registers and sequences mult/multu/div/divu over a fixed cycle count. Serves mfhi/mflo reads and handles mthi/mtlo writes.
- Raises a D-stage stall request so that any HI/LO-using instruction in D waits while the unit is occupied.
- Its stall request is ORed with the GRF-hazard stall by the top level.

---
 rtl/md_unit_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/md_unit_ctrl.sv
// Multiply/divide controller for the E stage: owns HI/LO, runs mult/div over a
// fixed busy period, serves mfhi/mflo/mthi/mtlo and raises the D-stage stall.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_md_op,
  input  logic [31:0] E_rs_data,
  input  logic [31:0] E_rt_data,
  input  logic        D_md_instr,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] E_md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [31:0]       pend_hi, pend_lo;
  logic              pend_valid;

  logic              is_start, is_div, start_accept, commit;
  logic [31:0]       res_hi, res_lo;
  logic [63:0]       prod_s, prod_u;
  logic              a_neg, b_neg, div_zero;
  logic [31:0]       a_mag, b_mag, b_safe_s, b_safe_u;
  logic [31:0]       uq, ur, dq, dr;

  assign is_start = (E_md_op == OP_MULT) || (E_md_op == OP_MULTU) ||
                    (E_md_op == OP_DIV)  || (E_md_op == OP_DIVU);
  assign is_div   = (E_md_op == OP_DIV) || (E_md_op == OP_DIVU);
  assign div_zero = (E_rt_data == 32'd0);

  // Explicit extension keeps the 64-bit products exact for both signednesses.
  assign prod_s = {{32{E_rs_data[31]}}, E_rs_data} * {{32{E_rt_data[31]}}, E_rt_data};
  assign prod_u = {32'd0, E_rs_data} * {32'd0, E_rt_data};

  // Signed divide via magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
  assign a_neg    = E_rs_data[31];
  assign b_neg    = E_rt_data[31];
  assign a_mag    = a_neg ? -E_rs_data : E_rs_data;
  assign b_mag    = b_neg ? -E_rt_data : E_rt_data;
  assign b_safe_s = div_zero ? 32'd1 : b_mag;
  assign b_safe_u = div_zero ? 32'd1 : E_rt_data;
  assign uq       = a_mag / b_safe_s;
  assign ur       = a_mag % b_safe_s;
  assign dq       = E_rs_data / b_safe_u;
  assign dr       = E_rs_data % b_safe_u;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (E_md_op)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      OP_DIV:   begin
        res_lo = (a_neg ^ b_neg) ? -uq : uq;
        res_hi = a_neg ? -ur : ur;
      end
      OP_DIVU:  begin res_hi = dr; res_lo = dq; end
      default:  begin res_hi = 32'd0; res_lo = 32'd0; end
    endcase
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    start_accept = 1'b0;
    commit       = 1'b0;
    case (state)
      IDLE: begin
        if (is_start) begin
          start_accept = 1'b1;
          state_next   = BUSY;
          cnt_next     = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      BUSY: begin
        if (cnt == CNT_W'(1)) begin
          commit     = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      pend_hi    <= 32'd0;
      pend_lo    <= 32'd0;
      pend_valid <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (start_accept) begin
        pend_hi    <= res_hi;
        pend_lo    <= res_lo;
        pend_valid <= !(is_div && div_zero);
      end
      if (state == IDLE && E_md_op == OP_MTHI) hi <= E_rs_data;
      if (state == IDLE && E_md_op == OP_MTLO) lo <= E_rs_data;
      if (commit && pend_valid) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

  assign busy     = (state == BUSY);
  assign md_stall = D_md_instr & (busy | is_start);
  assign E_md_out = (E_md_op == OP_MFHI) ? hi :
                    (E_md_op == OP_MFLO) ? lo : 32'd0;

endmodule
